// File: rtl/shift_left26.sv
// shift_left26: jump-target shifter for the MIPS datapath.
// Shifts the 26-bit J-type instruction index left by SHIFT bits to form the
// word-aligned 28-bit byte offset that is later concatenated with PC[31:28].
//
// Build option:
//   SHIFTLEFT26_OUTREG_EN defined   -> output registered on Clk (1-cycle
//                                      latency, synchronous active-high Reset
//                                      clears the output to 0).
//   SHIFTLEFT26_OUTREG_EN undefined -> purely combinational; Clk and Reset are
//                                      kept in the port list but unused, so
//                                      both builds instantiate identically.
module shift_left26 #(
  parameter int IN_W  = 26,
  parameter int SHIFT = 2,
  // Derived; keep it equal to IN_W + SHIFT so no shifted bit is lost.
  parameter int OUT_W = IN_W + SHIFT
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [IN_W-1:0]  in,
  output logic [OUT_W-1:0] out
);

  // Logical left shift: index lands in the upper bits, the byte-offset bits
  // below it are constant zero, and nothing is sign-extended.
  function automatic logic [OUT_W-1:0] word_to_byte(input logic [IN_W-1:0] idx);
    return {idx, {SHIFT{1'b0}}};
  endfunction

  // Stage 0: combinational shift of the incoming index.
  logic [OUT_W-1:0] shifted_p0;
  assign shifted_p0 = word_to_byte(in);

`ifdef SHIFTLEFT26_OUTREG_EN

  // Only the index bits are stored; the low SHIFT bits are tied to zero so
  // they read 0 even before the first reset edge.
  logic [IN_W-1:0] idx_p1;

  // Stage 1: output register, reset has priority over loading a new index.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      idx_p1 <= '0;
    end else begin
      idx_p1 <= shifted_p0[OUT_W-1:SHIFT];
    end
  end

  assign out = {idx_p1, {SHIFT{1'b0}}};

`else

  // Clk and Reset are deliberately unused in the combinational build.
  logic unused_clk_rst;
  assign unused_clk_rst = &{1'b0, Clk, Reset};

  assign out = shifted_p0;

`endif

endmodule

// File: tb/tb_shift_left26.sv
// tb_shift_left26: directed self-checking bench for shift_left26.
// Covers the registered build when SHIFTLEFT26_OUTREG_EN is defined and the
// combinational build otherwise.
module tb_shift_left26;

  logic        Clk;
  logic        Reset;
  logic [25:0] in;
  logic [27:0] out;

  int checks;
  int failures;

  shift_left26 dut (
    .Clk   (Clk),
    .Reset (Reset),
    .in    (in),
    .out   (out)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [27:0] obs, input logic [27:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply inputs, take one rising edge, then sample 1 time unit later.
  task automatic step(input logic [25:0] val, input logic rst);
    in    = val;
    Reset = rst;
    @(posedge Clk);
    #1;
  endtask

  initial begin
    logic [27:0] exp;
    checks   = 0;
    failures = 0;
    in       = '0;
    Reset    = 1'b1;
    #1;

`ifdef SHIFTLEFT26_OUTREG_EN
    // Reset held for two edges with all-ones on the input.
    step(26'h3FFFFFF, 1'b1);
    check("reset_edge1", out, 28'h0000000);
    step(26'h3FFFFFF, 1'b1);
    check("reset_edge2", out, 28'h0000000);

    // Release reset with zero input, then MSB-clear all-ones pattern.
    step(26'h0000000, 1'b0);
    check("release_zero", out, 28'h0000000);
    in = 26'h1FFFFFF;
    #2;
    check("latency_hold", out, 28'h0000000);
    step(26'h1FFFFFF, 1'b0);
    check("pattern_1ffffff", out, 28'h7FFFFFC);
    check("low_bits_zero", {26'h0, out[1:0]}, 28'h0000000);

    // Full ones and MSB/LSB pattern.
    step(26'h3FFFFFF, 1'b0);
    check("pattern_3ffffff", out, 28'hFFFFFFC);
    step(26'h2000001, 1'b0);
    check("pattern_2000001", out, 28'h8000004);

    // Walking one across every index bit.
    for (int k = 0; k < 26; k++) begin
      exp = 28'h0000001 << (k + 2);
      step(26'h0000001 << k, 1'b0);
      check($sformatf("walk1_k%0d", k), out, exp);
    end

    // Reset asserted mid-stream discards that edge's load.
    step(26'h155AAAA, 1'b1);
    check("midstream_reset", out, 28'h0000000);
    step(26'h155AAAA, 1'b0);
    check("after_reset_load", out, 28'h556AAA8);

    // Only the value present at the sampling edge is taken.
    in = 26'h0ABCDEF;
    #2;
    in = 26'h2000001;
    @(posedge Clk);
    #1;
    check("sample_at_edge", out, 28'h8000004);

    // Unknown input reaches only the index bits.
    step('x, 1'b0);
    check("x_propagation", out, {26'bx, 2'b00});
    step(26'h0ABCDEF, 1'b0);
    check("recover_after_x", out, 28'h2AF37BC);
`else
    // Combinational build: output follows input without a clock edge.
    in = 26'h0ABCDEF;
    #1;
    check("comb_abcdef", out, 28'h2AF37BC);
    Reset = 1'b0;
    #1;
    check("comb_reset_low", out, 28'h2AF37BC);
    Reset = 1'b1;
    #1;
    check("comb_reset_high", out, 28'h2AF37BC);
    @(posedge Clk);
    #1;
    check("comb_after_edge", out, 28'h2AF37BC);

    in = 26'h1FFFFFF;
    #1;
    check("comb_1ffffff", out, 28'h7FFFFFC);
    in = 26'h3FFFFFF;
    #1;
    check("comb_3ffffff", out, 28'hFFFFFFC);
    in = 26'h2000001;
    #1;
    check("comb_2000001", out, 28'h8000004);
    in = 26'h155AAAA;
    #1;
    check("comb_155aaaa", out, 28'h556AAA8);
    in = 26'h0000000;
    #1;
    check("comb_zero", out, 28'h0000000);

    for (int k = 0; k < 26; k++) begin
      exp = 28'h0000001 << (k + 2);
      in  = 26'h0000001 << k;
      #1;
      check($sformatf("comb_walk1_k%0d", k), out, exp);
    end

    in = 'x;
    #1;
    check("comb_x_propagation", out, {26'bx, 2'b00});
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shift_left26.md
# shift_left26

Jump-target shifter for the MIPS datapath. Takes the 26-bit instruction index field of a J-type instruction and shifts it left by two, giving the 28-bit word-aligned byte offset. The jump-address logic concatenates that offset with PC[31:28]. The output is registered on the datapath clock by default. A compile-time macro selects a purely combinational variant instead.

## Interface

Parameters:
- `IN_W`, default 26: width of the instruction index input.
- `SHIFT`, default 2: fixed left-shift amount (byte offset of a word).
- `OUT_W`, default `IN_W + SHIFT` (28): output width. It is derived from the other two and must not be overridden on its own.

Ports:
- `Clk`  input  1: datapath clock; all state updates on the rising edge.
- `Reset`  input  1: reset, synchronous and active-high.
- `in`  input  `IN_W` (26): instruction index field, instr[25:0].
- `out`  output  `OUT_W` (28): shifted jump offset.

## Operation

- Function: `out = {in, SHIFT'b0}`, i.e. `out[27:2] = in[25:0]` and `out[1:0] = 2'b00`.
- The shift is logical:
  - no bits are lost;
  - the MSB of `in` becomes `out[27]`;
  - there is no sign extension.
- `out[1:0]` is always 0 in every mode, including during and after reset.
- No arithmetic, no saturation, no wrap-around: the output width covers the full shifted value.
- X/Z on `in` propagates to `out[27:2]` only; `out[1:0]` stays 0.
- There is no handshake. The block samples `in` on every clock edge (registered mode) or continuously (combinational mode).

## Timing

Registered mode (default):
- `out` is a 28-bit register loaded on each rising edge of `Clk`.
- Latency is exactly 1 cycle: a value on `in` set before edge N appears on `out` after edge N.
- `Reset` high at a rising edge forces `out` to 28'h0000000. Reset has priority over loading `in`.
- Reset asserted mid-stream: the value loaded at that edge is discarded, and `out` is 0 from that edge onward.
- First edge with `Reset` low: `out` loads the current `in`.
- Reset value of `out` is 0.
- Before the first reset or clock edge, `out` is unknown. Integrators must not consume `out` until after reset.
- If `in` changes between edges, `out` takes only the value present at the sampling edge.

Combinational mode:
- `out` follows `in` with zero cycles of latency.
- `Clk` and `Reset` are ignored.
- There is no reset value; `out` always equals `{in, 2'b00}`.

## Configuration

Macro `SHIFTLEFT26_OUTREG_EN`:
- Defined: the output register described above is present.
  - One cycle of latency.
  - Synchronous reset to 0.
  - `Clk` and `Reset` are functional.
- Not defined: `out` is a continuous assignment of `{in, 2'b00}`.
  - `Clk` and `Reset` stay in the port list but are unused, so instantiations are identical in both builds.
- The project build defines the macro by default.

## Test plan

1. Reset held high for 2 edges while `in` = 26'h3FFFFFF -> `out` = 28'h0000000 after the first edge (registered build).
2. Release reset, `in` = 0, then `in` = 26'b01111111111111111111111111 (26'h1FFFFFF) -> `out` = 28'h7FFFFFC one edge later; `out[1:0]` = 0 throughout.
3. `in` = 26'h3FFFFFF -> `out` = 28'hFFFFFFC. Then `in` = 26'h2000001 -> `out` = 28'h8000004. Each appears one edge after it is applied.
4. Walking-one, 26 vectors on consecutive edges: `in` = 1 << k for k = 0..25 -> `out` = 1 << (k+2) on the following edge, with no other bits set.
5. Reset asserted for one edge while streaming `in` = 26'h155AAAA -> `out` = 0 at that edge. The next edge, with reset low, gives `out` = 28'h556AAA8.
6. Combinational build (macro undefined): `in` = 26'h0ABCDEF -> `out` = 28'h2AF37BC immediately, with no clock edge; toggling `Reset` has no effect.
